// File: rtl/soh_ctrl_stage_pkg.sv
// Shared definitions for the SOH control stage: opcodes, selector codes, field widths, state encoding.
package soh_ctrl_stage_pkg;

    localparam int INST_W = 32;
    localparam int IMM_W  = 21;
    localparam int OP_W   = 6;

    localparam logic [OP_W-1:0] OP_ALU   = 6'h02;
    localparam logic [OP_W-1:0] OP_SUBI  = 6'h25;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h2D;
    localparam logic [OP_W-1:0] OP_LDO   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LDW   = 6'h12;
    localparam logic [OP_W-1:0] OP_STW   = 6'h1A;
    localparam logic [OP_W-1:0] OP_LDIL  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIL = 6'h0A;
    localparam logic [OP_W-1:0] OP_EXTRW = 6'h34;
    localparam logic [OP_W-1:0] OP_DEPW  = 6'h35;

    typedef enum logic [2:0] {
        SEL_RB   = 3'b000,
        SEL_IMM  = 3'b001,
        SEL_MEM  = 3'b010,
        SEL_LONG = 3'b011,
        SEL_EXTL = 3'b100,
        SEL_EXTA = 3'b101,
        SEL_DEP  = 3'b110,
        SEL_DEF  = 3'b111
    } soh_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic logic [OP_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[31:26];
    endfunction

endpackage

// File: rtl/soh_ctrl_stage_if.sv
// Decode-side and EX-side handshake bundle of the SOH control stage.
interface soh_ctrl_stage_if
    import soh_ctrl_stage_pkg::*;
#(
    parameter int DW = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] inst;
    logic [DW-1:0]     rb;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        soh_s;
    logic [IMM_W-1:0]  soh_i;
    logic [DW-1:0]     soh_rb;
    logic              illegal;

    modport master (
        output in_valid, inst, rb, out_ready,
        input  in_ready, out_valid, soh_s, soh_i, soh_rb, illegal
    );

    modport slave (
        input  in_valid, inst, rb, out_ready,
        output in_ready, out_valid, soh_s, soh_i, soh_rb, illegal
    );
endinterface

// File: rtl/soh_ctrl_decode.sv
// Combinational opcode decode into the SOH selector and an illegal-opcode flag.
module soh_ctrl_decode
    import soh_ctrl_stage_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    input  logic            ext_arith,
    output soh_sel_e        sel,
    output logic            illegal
);

    always_comb begin
        sel     = SEL_DEF;
        illegal = 1'b0;
        case (opcode)
            OP_ALU:                  sel = SEL_RB;
            OP_SUBI, OP_ADDI:        sel = SEL_IMM;
            OP_LDO, OP_LDW, OP_STW:  sel = SEL_MEM;
            OP_LDIL, OP_ADDIL:       sel = SEL_LONG;
            OP_EXTRW:                sel = ext_arith ? SEL_EXTA : SEL_EXTL;
            OP_DEPW:                 sel = SEL_DEP;
            default:                 illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/soh_ctrl_stage.sv
// ID->EX stage feeding the SOH: main register M plus skid register K, registered handshakes.
// Define SOH_CTRL_ILLEGAL_TRAP_EN to hold illegal entries in M (sticky illegal, never issued) until flush/reset.
module soh_ctrl_stage
    import soh_ctrl_stage_pkg::*;
#(
    parameter int DW = 32
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    soh_ctrl_stage_if.slave bus
);

`ifdef SOH_CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    stage_state_e     state;
    logic             in_ready_q;
    logic             out_valid_q;

    soh_sel_e         m_sel;
    logic [IMM_W-1:0] m_imm;
    logic [DW-1:0]    m_rb;
    logic             m_illegal;

    soh_sel_e         k_sel;
    logic [IMM_W-1:0] k_imm;
    logic [DW-1:0]    k_rb;
    logic             k_illegal;

    soh_sel_e         dec_sel;
    logic             dec_illegal;
    logic             accept;
    logic             consume;
    logic             unused_inst_bits;

    soh_ctrl_decode u_decode (
        .opcode    (opcode_of(bus.inst)),
        .ext_arith (bus.inst[12]),
        .sel       (dec_sel),
        .illegal   (dec_illegal)
    );

    assign accept           = bus.in_valid & in_ready_q;
    assign consume          = out_valid_q & bus.out_ready;
    assign unused_inst_bits = ^bus.inst[25:21];

    // A trapped illegal entry sits in M with out_valid low, so it can never be consumed.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_sel       <= SEL_DEF;
            m_imm       <= '0;
            m_rb        <= '0;
            m_illegal   <= 1'b0;
            k_sel       <= SEL_DEF;
            k_imm       <= '0;
            k_rb        <= '0;
            k_illegal   <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state       <= ST_ONE;
                        out_valid_q <= ~(TRAP_EN & dec_illegal);
                        m_sel       <= dec_sel;
                        m_imm       <= bus.inst[IMM_W-1:0];
                        m_rb        <= bus.rb;
                        m_illegal   <= dec_illegal;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        out_valid_q <= ~(TRAP_EN & dec_illegal);
                        m_sel       <= dec_sel;
                        m_imm       <= bus.inst[IMM_W-1:0];
                        m_rb        <= bus.rb;
                        m_illegal   <= dec_illegal;
                    end else if (accept) begin
                        state      <= ST_FULL;
                        in_ready_q <= 1'b0;
                        k_sel      <= dec_sel;
                        k_imm      <= bus.inst[IMM_W-1:0];
                        k_rb       <= bus.rb;
                        k_illegal  <= dec_illegal;
                    end else if (consume) begin
                        state       <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                        m_sel       <= SEL_DEF;
                        m_imm       <= '0;
                        m_rb        <= '0;
                        m_illegal   <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state       <= ST_ONE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= ~(TRAP_EN & k_illegal);
                        m_sel       <= k_sel;
                        m_imm       <= k_imm;
                        m_rb        <= k_rb;
                        m_illegal   <= k_illegal;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.soh_s     = m_sel;
    assign bus.soh_i     = m_imm;
    assign bus.soh_rb    = m_rb;
    assign bus.illegal   = m_illegal;

endmodule

// File: tb/tb_soh_ctrl_stage.sv
// Directed bench for soh_ctrl_stage: reset, decode sweep, backpressure, flush, mid-stream reset, illegal handling.
module tb_soh_ctrl_stage;
    import soh_ctrl_stage_pkg::*;

`ifdef SOH_CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    soh_ctrl_stage_if #(.DW(32)) bus ();

    soh_ctrl_stage #(.DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] inst, input logic [31:0] rb,
                                  input logic ordy);
        bus.in_valid  = v;
        bus.inst      = inst;
        bus.rb        = rb;
        bus.out_ready = ordy;
    endtask

    task automatic check_output(input string tag, input logic ov, input logic ir, input logic [2:0] s,
                                input logic [20:0] imm, input logic [31:0] rb, input logic ill);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
        check({tag, ".soh_s"},     32'(bus.soh_s),     32'(s));
        check({tag, ".soh_i"},     32'(bus.soh_i),     32'(imm));
        check({tag, ".soh_rb"},    bus.soh_rb,         rb);
        check({tag, ".illegal"},   32'(bus.illegal),   32'(ill));
    endtask

    logic [31:0] sw_inst [12] = '{32'h08012345, 32'h94000002, 32'hB41ABCDE, 32'h34000100,
                                  32'h48300FFF, 32'h68000004, 32'h20000001, 32'h28000010,
                                  32'hD0000FFF, 32'hD0001000, 32'hD41FFFFF, 32'hFC000055};
    logic [2:0]  sw_s    [12] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3,
                                  3'd4, 3'd5, 3'd6, 3'd7};
    logic [20:0] sw_imm  [12] = '{21'h012345, 21'h000002, 21'h1ABCDE, 21'h000100,
                                  21'h100FFF, 21'h000004, 21'h000001, 21'h000010,
                                  21'h000FFF, 21'h001000, 21'h1FFFFF, 21'h000055};
    logic        sw_ill  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        $display("[TB] start, trap mode = %0d", TRAP);
        reset = 1'b1;
        flush = 1'b0;
        apply_stimulus(1'b1, 32'h08000000, 32'hDEADBEEF, 1'b0);

        // Reset held two cycles with in_valid high must leave the stage empty.
        tick();
        tick();
        check_output("reset", 1'b0, 1'b1, 3'b111, 21'h0, 32'h0, 1'b0);
        reset = 1'b0;
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        check("reset.idle.out_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back decode sweep with out_ready held high.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, sw_inst[i], 32'h10000000 | 32'(i), 1'b1);
            tick();
            check_output($sformatf("sweep%0d", i), ~(TRAP & sw_ill[i]), 1'b1, sw_s[i], sw_imm[i],
                         32'h10000000 | 32'(i), sw_ill[i]);
        end
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("sweep.flush", 1'b0, 1'b1, 3'b111, 21'h0, 32'h0, 1'b0);

        // Backpressure: A,B fill M and K, C waits, then release.
        apply_stimulus(1'b1, 32'h08000011, 32'hA0A0A0A0, 1'b0);
        tick();
        check_output("bp.a", 1'b1, 1'b1, 3'd0, 21'h11, 32'hA0A0A0A0, 1'b0);
        apply_stimulus(1'b1, 32'hB4000022, 32'hB0B0B0B0, 1'b0);
        tick();
        check_output("bp.full", 1'b1, 1'b0, 3'd0, 21'h11, 32'hA0A0A0A0, 1'b0);
        apply_stimulus(1'b1, 32'h48000033, 32'hC0C0C0C0, 1'b0);
        tick();
        check_output("bp.frozen", 1'b1, 1'b0, 3'd0, 21'h11, 32'hA0A0A0A0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check_output("bp.b", 1'b1, 1'b1, 3'd1, 21'h22, 32'hB0B0B0B0, 1'b0);
        tick();
        check_output("bp.c", 1'b1, 1'b1, 3'd2, 21'h33, 32'hC0C0C0C0, 1'b0);
        apply_stimulus(1'b1, 32'h20000044, 32'hD0D0D0D0, 1'b1);
        tick();
        check_output("bp.d", 1'b1, 1'b1, 3'd3, 21'h44, 32'hD0D0D0D0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        check("bp.drain.out_valid", 32'(bus.out_valid), 32'd0);

        // Flush while FULL with a simultaneous accept attempt.
        apply_stimulus(1'b1, 32'h08000001, 32'h11111111, 1'b0);
        tick();
        apply_stimulus(1'b1, 32'h08000002, 32'h22222222, 1'b0);
        tick();
        check("fl.full.in_ready", 32'(bus.in_ready), 32'd0);
        bus.rb = 32'h33333333;
        bus.in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("fl.flushed", 1'b0, 1'b1, 3'b111, 21'h0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        check("fl.dropped.out_valid", 32'(bus.out_valid), 32'd0);

        // Reset mid-stream while FULL.
        apply_stimulus(1'b1, 32'hD4000005, 32'h55555555, 1'b0);
        tick();
        apply_stimulus(1'b1, 32'hD0001006, 32'h66666666, 1'b0);
        tick();
        check("rs.full.in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        tick();
        check_output("rs.reset", 1'b0, 1'b1, 3'b111, 21'h0, 32'h0, 1'b0);
        reset = 1'b0;
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        check("rs.idle.out_valid", 32'(bus.out_valid), 32'd0);

        // Illegal opcode followed by a legal one.
        apply_stimulus(1'b1, 32'hFC000007, 32'h77777777, 1'b1);
        tick();
`ifdef SOH_CTRL_ILLEGAL_TRAP_EN
        check_output("il.trap", 1'b0, 1'b1, 3'd7, 21'h7, 32'h77777777, 1'b1);
        apply_stimulus(1'b1, 32'h08000008, 32'h88888888, 1'b1);
        tick();
        check_output("il.stall", 1'b0, 1'b0, 3'd7, 21'h7, 32'h77777777, 1'b1);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        check_output("il.sticky", 1'b0, 1'b0, 3'd7, 21'h7, 32'h77777777, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("il.flush", 1'b0, 1'b1, 3'b111, 21'h0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 32'h08000009, 32'h99999999, 1'b1);
        tick();
        check_output("il.resume", 1'b1, 1'b1, 3'd0, 21'h9, 32'h99999999, 1'b0);
`else
        check_output("il.issue", 1'b1, 1'b1, 3'd7, 21'h7, 32'h77777777, 1'b1);
        apply_stimulus(1'b1, 32'h08000008, 32'h88888888, 1'b1);
        tick();
        check_output("il.next", 1'b1, 1'b1, 3'd0, 21'h8, 32'h88888888, 1'b0);
`endif
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        check("il.drain.out_valid", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
